kernel_pio_irq_servicer: RTL and testbench

//  Avalon-MM initiator that services the single-bit edge-capture input PIO (s1 slave: addr 0 data,
//  2 irqmask, 3 edgecapture). On irq, or on a poll tick, it reads edgecapture, clears it, reads the
//  pin level, and emits one event on a valid/ready stream. Sits between the PIO slave and kernel

---
 rtl/kernel_pio_irq_servicer_pkg.sv | 20 ++
 rtl/kernel_pio_irq_servicer.sv | 124 ++++++++++++
 tb/tb_kernel_pio_irq_servicer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_pio_irq_servicer_pkg.sv
// Shared definitions for the PIO edge-capture servicer: PIO register map and FSM states.
package kernel_pio_irq_servicer_pkg;

    // PIO s1 word addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_CAP,
        ST_WT_CAP,
        ST_CLR,
        ST_RD_DAT,
        ST_WT_DAT,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/kernel_pio_irq_servicer.sv
// Avalon-MM initiator that services a single-bit edge-capture PIO: on irq or a
// poll tick it reads edgecapture, clears it, samples the pin and emits one event.
module kernel_pio_irq_servicer
    import kernel_pio_irq_servicer_pkg::*;
#(
    parameter bit MASK_INIT   = 1'b1,
    parameter int POLL_CYCLES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [CNT_W-1:0] evt_count
);

    localparam int TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST =
        (POLL_CYCLES > 0) ? TMR_W'(POLL_CYCLES - 1) : '0;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             poll_hit;
    logic             unused_rd;

    // Only the pin/capture bit carries information
    assign unused_rd = ^avm_readdata[31:1];

    assign poll_hit = (POLL_CYCLES > 0) && (tmr == TMR_LAST);

    // State register; reset always lands in INIT so the mask write is reissued
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // Next-state and Moore bus decode; bus forced idle while reset is held
    always_comb begin
        state_nxt      = state;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = ADDR_DATA;
        avm_writedata  = '0;
        case (state)
            ST_INIT: begin
                state_nxt = ST_IDLE;
                if (!reset) begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = ADDR_MASK;
                    avm_writedata  = {31'b0, MASK_INIT};
                end
            end
            ST_IDLE: begin
                if (irq || poll_hit) state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_nxt = ST_WT_CAP;
                if (!reset) begin
                    avm_chipselect = 1'b1;
                    avm_address    = ADDR_EDGE;
                end
            end
            ST_WT_CAP: begin
                // No captured edge means a spurious irq or an empty poll
                state_nxt   = avm_readdata[0] ? ST_CLR : ST_IDLE;
                avm_address = ADDR_EDGE;
            end
            ST_CLR: begin
                state_nxt = ST_RD_DAT;
                if (!reset) begin
                    avm_chipselect = 1'b1;
                    avm_write_n    = 1'b0;
                    avm_address    = ADDR_EDGE;
                end
            end
            ST_RD_DAT: begin
                state_nxt = ST_WT_DAT;
                if (!reset) avm_chipselect = 1'b1;
            end
            ST_WT_DAT: begin
                state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                // Bus stays quiet until downstream takes the event
                if (evt_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Poll timer: runs only while idle, cleared whenever IDLE is left or not occupied
    always_ff @(posedge clk) begin
        if (reset)
            tmr <= '0;
        else if (POLL_CYCLES > 0 && state == ST_IDLE && state_nxt == ST_IDLE)
            tmr <= tmr + 1'b1;
        else
            tmr <= '0;
    end

    // Event output register and saturating accepted-event counter
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid <= 1'b0;
            evt_level <= 1'b0;
            evt_count <= '0;
        end else if (state == ST_WT_DAT) begin
            evt_valid <= 1'b1;
            evt_level <= avm_readdata[0];
        end else if (state == ST_EMIT && evt_ready) begin
            evt_valid <= 1'b0;
            if (evt_count != '1) evt_count <= evt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_kernel_pio_irq_servicer.sv
// Bench for kernel_pio_irq_servicer: two instances (irq-driven, and poll-only with a
// 2-bit counter), each on its own PIO slave model, with bus and event scoreboards.
module tb_kernel_pio_irq_servicer;
    import kernel_pio_irq_servicer_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } bus_t;

    typedef struct {
        logic level;
        int   cnt;
    } evt_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        cs, wr_n, in_port, in_prev, edge_cap, irq_mask, irq;
    logic [1:0][1:0]   addr;
    logic [1:0][31:0]  wdata, rdata;
    logic [1:0]        evt_valid, evt_ready, evt_level;
    logic [15:0]       cnt_a;
    logic [1:0]        cnt_p;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt_a = 0;
    int   exp_cnt_p = 0;
    bus_t bus_q0[$], bus_q1[$];
    evt_t exp_q0[$], exp_q1[$];

    always #5 clk = ~clk;

    kernel_pio_irq_servicer #(.MASK_INIT(1'b1), .POLL_CYCLES(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .avm_address(addr[0]), .avm_chipselect(cs[0]), .avm_write_n(wr_n[0]),
        .avm_writedata(wdata[0]), .avm_readdata(rdata[0]), .irq(irq[0]),
        .evt_valid(evt_valid[0]), .evt_ready(evt_ready[0]), .evt_level(evt_level[0]),
        .evt_count(cnt_a)
    );

    kernel_pio_irq_servicer #(.MASK_INIT(1'b0), .POLL_CYCLES(8), .CNT_W(2)) dut_p (
        .clk(clk), .reset(reset),
        .avm_address(addr[1]), .avm_chipselect(cs[1]), .avm_write_n(wr_n[1]),
        .avm_writedata(wdata[1]), .avm_readdata(rdata[1]), .irq(irq[1]),
        .evt_valid(evt_valid[1]), .evt_ready(evt_ready[1]), .evt_level(evt_level[1]),
        .evt_count(cnt_p)
    );

    assign irq = edge_cap & irq_mask;

    // PIO slave models: registered readdata, rising-edge capture, write to edgecapture clears
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            in_prev[g] <= in_port[g];
            if (reset) begin
                edge_cap[g] <= 1'b0;
                irq_mask[g] <= 1'b0;
                rdata[g]    <= '0;
            end else begin
                if (in_port[g] && !in_prev[g]) edge_cap[g] <= 1'b1;
                if (cs[g] && !wr_n[g] && addr[g] == ADDR_EDGE) edge_cap[g] <= 1'b0;
                if (cs[g] && !wr_n[g] && addr[g] == ADDR_MASK) irq_mask[g] <= wdata[g][0];
                if (cs[g] && wr_n[g])
                    rdata[g] <= {31'h2AAA_AAAA,
                                 (addr[g] == ADDR_EDGE) ? edge_cap[g] :
                                 (addr[g] == ADDR_MASK) ? irq_mask[g] : in_port[g]};
            end
        end
    end

    // Bus monitor: log every selected cycle with the cycle it occupied
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs[0]) bus_q0.push_back('{wr: !wr_n[0], addr: addr[0], data: wdata[0], cyc: cyc});
        if (cs[1]) bus_q1.push_back('{wr: !wr_n[1], addr: addr[1], data: wdata[1], cyc: cyc});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input int g, input logic wr,
                           input logic [1:0] a, input logic [31:0] d);
        bus_t t;
        int   sz;
        sz = (g == 0) ? bus_q0.size() : bus_q1.size();
        if (sz == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        if (g == 0) t = bus_q0.pop_front();
        else        t = bus_q1.pop_front();
        chk({tag, "_wr"}, {31'b0, t.wr}, {31'b0, wr});
        chk({tag, "_addr"}, {30'b0, t.addr}, {30'b0, a});
        if (wr) chk({tag, "_data"}, t.data, d);
    endtask

    // Wait for a handshake, pop the scoreboard and check level then post-handshake count
    task automatic wait_evt(input int g, input int max, output int vcyc);
        evt_t e;
        bit   got;
        int   sz;
        logic [31:0] cnt;
        got  = 1'b0;
        vcyc = -1;
        for (int i = 0; i < max && !got; i++) begin
            if (evt_valid[g] && evt_ready[g]) got = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("evt_seen%0d", g), {31'b0, got}, 32'd1);
        if (!got) return;
        vcyc = cyc;
        sz = (g == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            chk($sformatf("evt_expected%0d", g), 32'd0, 32'd1);
            return;
        end
        if (g == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk($sformatf("evt_level%0d", g), {31'b0, evt_level[g]}, {31'b0, e.level});
        @(negedge clk);
        cnt = (g == 0) ? {16'b0, cnt_a} : {30'b0, cnt_p};
        chk($sformatf("evt_count%0d", g), cnt, e.cnt);
        chk($sformatf("evt_drop%0d", g), {31'b0, evt_valid[g]}, 32'd0);
    endtask

    initial begin
        int   t0, vc;
        bus_t b;
        bit   seen;

        reset     = 1'b1;
        in_port   = 2'b00;
        evt_ready = 2'b11;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'b0, cs[0]}, 32'd0);
        chk("rst_wr_n", {31'b0, wr_n[0]}, 32'd1);
        chk("rst_addr", {30'b0, addr[0]}, 32'd0);
        chk("rst_wdata", wdata[0], 32'd0);
        chk("rst_valid", {30'b0, evt_valid}, 32'd0);
        chk("rst_level", {31'b0, evt_level[0]}, 32'd0);
        chk("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
        chk("rst_cnt_p", {30'b0, cnt_p}, 32'd0);
        chk("rst_nobus", bus_q0.size() + bus_q1.size(), 32'd0);

        // one mask write in the first cycle after release, then idle
        reset = 1'b0;
        t0 = cyc;
        repeat (5) @(negedge clk);
        chk("init_count_a", bus_q0.size(), 32'd1);
        if (bus_q0.size() > 0) chk("init_cyc_a", bus_q0[0].cyc, t0);
        chk_bus("init_a", 0, 1'b1, ADDR_MASK, 32'd1);
        chk("init_count_p", bus_q1.size(), 32'd1);
        chk_bus("init_p", 1, 1'b1, ADDR_MASK, 32'd0);
        chk("init_valid", {30'b0, evt_valid}, 32'd0);

        // irq-driven event, latency and bus sequence
        bus_q0.delete();
        in_port[0] = 1'b1;
        exp_cnt_a++;
        exp_q0.push_back('{level: 1'b1, cnt: exp_cnt_a});
        @(negedge clk);
        chk("irq_up", {31'b0, irq[0]}, 32'd1);
        t0 = cyc;
        wait_evt(0, 12, vc);
        chk("latency", vc - t0, 32'd6);
        chk_bus("seq_rd3", 0, 1'b0, ADDR_EDGE, 32'd0);
        chk_bus("seq_wr3", 0, 1'b1, ADDR_EDGE, 32'd0);
        chk_bus("seq_rd0", 0, 1'b0, ADDR_DATA, 32'd0);
        chk("seq_len", bus_q0.size(), 32'd0);
        chk("irq_cleared", {31'b0, irq[0]}, 32'd0);

        // short pulse: edge captured but pin low when sampled
        in_port[0] = 1'b0;
        @(negedge clk);
        in_port[0] = 1'b1;
        @(negedge clk);
        in_port[0] = 1'b0;
        exp_cnt_a++;
        exp_q0.push_back('{level: 1'b0, cnt: exp_cnt_a});
        wait_evt(0, 15, vc);

        // stall downstream for 20 cycles with a second edge arriving meanwhile
        evt_ready[0] = 1'b0;
        @(negedge clk);
        in_port[0] = 1'b1;
        exp_cnt_a++;
        exp_q0.push_back('{level: 1'b1, cnt: exp_cnt_a});
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge clk);
            seen = evt_valid[0];
        end
        chk("stall_valid_up", {31'b0, seen}, 32'd1);
        bus_q0.delete();
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", {31'b0, evt_valid[0]}, 32'd1);
            chk("stall_level", {31'b0, evt_level[0]}, 32'd1);
            if (i == 3) in_port[0] = 1'b0;
            if (i == 5) begin
                in_port[0] = 1'b1;
                exp_cnt_a++;
                exp_q0.push_back('{level: 1'b1, cnt: exp_cnt_a});
            end
            @(negedge clk);
        end
        chk("stall_nobus", bus_q0.size(), 32'd0);
        chk("stall_irq", {31'b0, irq[0]}, 32'd1);
        evt_ready[0] = 1'b1;
        wait_evt(0, 2, vc);
        wait_evt(0, 15, vc);

        // poll-only instance: no edge -> capture reads every 10 cycles, no event
        bus_q1.delete();
        repeat (35) @(negedge clk);
        chk("poll_reads", {31'b0, bus_q1.size() >= 3}, 32'd1);
        for (int i = 0; i < bus_q1.size(); i++) begin
            b = bus_q1[i];
            chk("poll_is_rd", {31'b0, b.wr}, 32'd0);
            chk("poll_addr", {30'b0, b.addr}, {30'b0, ADDR_EDGE});
            if (i > 0) chk("poll_period", b.cyc - bus_q1[i-1].cyc, 32'd10);
        end
        chk("poll_noevt", {31'b0, evt_valid[1]}, 32'd0);

        // poll finds an edge
        in_port[1] = 1'b1;
        exp_cnt_p++;
        exp_q1.push_back('{level: 1'b1, cnt: exp_cnt_p});
        t0 = cyc;
        wait_evt(1, 20, vc);
        chk("poll_latency", {31'b0, (vc - t0) <= 16}, 32'd1);

        // saturation of the 2-bit counter over four more edges
        for (int k = 0; k < 4; k++) begin
            in_port[1] = 1'b0;
            @(negedge clk);
            in_port[1] = 1'b1;
            exp_cnt_p = (exp_cnt_p == 3) ? 3 : exp_cnt_p + 1;
            exp_q1.push_back('{level: 1'b1, cnt: exp_cnt_p});
            wait_evt(1, 25, vc);
        end

        // reset while holding an event in EMIT
        evt_ready[0] = 1'b0;
        in_port[0] = 1'b0;
        @(negedge clk);
        in_port[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            @(negedge clk);
            seen = evt_valid[0];
        end
        chk("emit_reached", {31'b0, seen}, 32'd1);
        repeat (2) @(negedge clk);
        bus_q0.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_emit_valid", {31'b0, evt_valid[0]}, 32'd0);
        chk("rst_emit_cnt", {16'b0, cnt_a}, 32'd0);
        chk("rst_emit_nobus", bus_q0.size(), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_cnt_a = 0;
        exp_cnt_p = 0;
        reset = 1'b0;
        @(negedge clk);
        chk_bus("reinit", 0, 1'b1, ADDR_MASK, 32'd1);
        evt_ready[0] = 1'b1;
        in_port[0] = 1'b0;
        @(negedge clk);
        in_port[0] = 1'b1;
        exp_cnt_a++;
        exp_q0.push_back('{level: 1'b1, cnt: exp_cnt_a});
        wait_evt(0, 15, vc);

        chk("sb_empty", exp_q0.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
